// File: rtl/regfile_mp.sv
// Multi-port integer register file with two prioritised write ports, optional
// same-cycle write-to-read bypass and a per-register busy scoreboard.

module regfile_mp_rdport #(
  parameter int DATA_WIDTH = 32,
  parameter int REGS_WIDTH = 5,
  parameter int NUM_WRITE  = 2,
  parameter int BYPASS     = 1,
  localparam int NREGS     = 1 << REGS_WIDTH
) (
  input  logic [REGS_WIDTH-1:0]                 ra_i,
  input  logic [NREGS-1:0][DATA_WIDTH-1:0]      regs_i,
  input  logic [NREGS-1:0]                      busy_i,
  input  logic [NUM_WRITE-1:0]                  wr_act_i,
  input  logic [NUM_WRITE-1:0][REGS_WIDTH-1:0]  wa_i,
  input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0]  wd_i,
  input  logic                                  alloc_act_i,
  input  logic [REGS_WIDTH-1:0]                 alloc_addr_i,
  output logic [DATA_WIDTH-1:0]                 data_o,
  output logic                                  busy_o
);
  logic retire;

  // x0 needs no special case: it is never written, bypassed or allocated.
  always_comb begin
    data_o = regs_i[ra_i];
    busy_o = busy_i[ra_i];
    retire = 1'b0;
    if (BYPASS != 0) begin
      // Ascending scan so the highest matching port index wins.
      for (int k = 0; k < NUM_WRITE; k++) begin
        if (wr_act_i[k] && (wa_i[k] == ra_i)) begin
          data_o = wd_i[k];
          retire = 1'b1;
        end
      end
      if (retire && !(alloc_act_i && (alloc_addr_i == ra_i)))
        busy_o = 1'b0;
    end
  end
endmodule

module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int REGS_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  parameter int BYPASS     = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cpu_en,
  input  logic [NUM_WRITE-1:0]            wr_en,
  input  logic [NUM_WRITE*REGS_WIDTH-1:0] wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_READ*REGS_WIDTH-1:0]  rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data,
  output logic [NUM_READ-1:0]             rd_busy,
  input  logic                            alloc_en,
  input  logic [REGS_WIDTH-1:0]           alloc_addr,
  output logic [REGS_WIDTH:0]             busy_count
);
  localparam int NREGS = 1 << REGS_WIDTH;
  localparam int CW    = REGS_WIDTH + 1;

  logic [NUM_WRITE-1:0][REGS_WIDTH-1:0] wa;
  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] wd;
  logic [NUM_READ-1:0][REGS_WIDTH-1:0]  ra;
  logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rdat;
  logic [NUM_WRITE-1:0]                 wr_act;
  logic                                 alloc_act;

  logic [NREGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NREGS-1:0]                 busy_q, busy_d;
  logic [CW-1:0]                    cnt_q, cnt_d;

  assign wa         = wr_addr;
  assign wd         = wr_data;
  assign ra         = rd_addr;
  assign rd_data    = rdat;
  assign busy_count = cnt_q;
  assign alloc_act  = cpu_en & alloc_en & (alloc_addr != '0);

  always_comb begin
    for (int k = 0; k < NUM_WRITE; k++)
      wr_act[k] = cpu_en & wr_en[k] & (wa[k] != '0);
  end

  // Writes retire the register; an allocate in the same cycle is applied last
  // so the newer producer keeps ownership.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int k = 0; k < NUM_WRITE; k++) begin
      if (wr_act[k]) begin
        regs_d[wa[k]] = wd[k];
        busy_d[wa[k]] = 1'b0;
      end
    end
    if (alloc_act) busy_d[alloc_addr] = 1'b1;
  end

  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < NREGS; r++) cnt_d = cnt_d + CW'(busy_d[r]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar j = 0; j < NUM_READ; j++) begin : g_rd
    regfile_mp_rdport #(
      .DATA_WIDTH(DATA_WIDTH), .REGS_WIDTH(REGS_WIDTH),
      .NUM_WRITE(NUM_WRITE),   .BYPASS(BYPASS)
    ) u_rd (
      .ra_i(ra[j]),
      .regs_i(regs_q),
      .busy_i(busy_q),
      .wr_act_i(wr_act),
      .wa_i(wa),
      .wd_i(wd),
      .alloc_act_i(alloc_act),
      .alloc_addr_i(alloc_addr),
      .data_o(rdat[j]),
      .busy_o(rd_busy[j])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, hand sequences for reset and
// the no-bypass timing, then random traffic against a behavioural model.

module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_en;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [9:0]  rd_addr;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic [5:0]  cnt_b, cnt_n;

  int checks = 0;
  int errors = 0;

  bit [4:0]  wa_v [2];
  bit [31:0] wd_v [2];
  bit [4:0]  ra_v [2];

  bit [31:0] mem [32];
  bit        bsy [32];

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_count(cnt_b));

  regfile_mp #(.BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_count(cnt_n));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit cen, input bit [1:0] we, input bit [4:0] a0,
                       input bit [31:0] d0, input bit [4:0] a1, input bit [31:0] d1,
                       input bit [4:0] r0, input bit [4:0] r1, input bit al,
                       input bit [4:0] aa);
    cpu_en = cen; wr_en = we; alloc_en = al; alloc_addr = aa;
    wa_v[0] = a0; wa_v[1] = a1; wd_v[0] = d0; wd_v[1] = d1;
    ra_v[0] = r0; ra_v[1] = r1;
    wr_addr = {a1, a0}; wr_data = {d1, d0}; rd_addr = {r1, r0};
  endtask

  task automatic idle_read(input bit [4:0] r0, input bit [4:0] r1);
    drive(1, 2'b00, 0, 0, 0, 0, r0, r1, 0, 0);
  endtask

  // Reference model: a register is the last enabled non-x0 write (highest port
  // last); busy is set by allocate after any retire in the same cycle.
  function automatic bit [31:0] exp_rd(input bit [4:0] a, input bit byp);
    if (a == 0) return 0;
    if (byp && cpu_en)
      for (int k = 1; k >= 0; k--)
        if (wr_en[k] && wa_v[k] == a) return wd_v[k];
    return mem[a];
  endfunction

  function automatic bit exp_busy(input bit [4:0] a, input bit byp);
    bit retire, realloc;
    if (a == 0) return 0;
    retire  = 0;
    realloc = alloc_en && (alloc_addr == a);
    if (byp && cpu_en) begin
      for (int k = 0; k < 2; k++) if (wr_en[k] && wa_v[k] == a) retire = 1;
      if (retire && !realloc) return 0;
    end
    return bsy[a];
  endfunction

  function automatic int busy_total();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(bsy[r]);
    return n;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin mem[r] = 0; bsy[r] = 0; end
  endtask

  task automatic model_edge();
    if (!cpu_en) return;
    for (int k = 0; k < 2; k++)
      if (wr_en[k] && wa_v[k] != 0) begin
        mem[wa_v[k]] = wd_v[k];
        bsy[wa_v[k]] = 0;
      end
    if (alloc_en && alloc_addr != 0) bsy[alloc_addr] = 1;
  endtask

  task automatic check_model(input string tag);
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("%s rd_byp[%0d]", tag, j), rd_data_b[j*32 +: 32], exp_rd(ra_v[j], 1));
      chk($sformatf("%s rd_nob[%0d]", tag, j), rd_data_n[j*32 +: 32], exp_rd(ra_v[j], 0));
      chk($sformatf("%s busy_byp[%0d]", tag, j), rd_busy_b[j], exp_busy(ra_v[j], 1));
      chk($sformatf("%s busy_nob[%0d]", tag, j), rd_busy_n[j], exp_busy(ra_v[j], 0));
    end
    chk($sformatf("%s cnt_byp", tag), cnt_b, busy_total());
    chk($sformatf("%s cnt_nob", tag), cnt_n, busy_total());
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
  endtask

  typedef struct {
    bit        cen;
    bit [1:0]  we;
    bit [4:0]  a0, a1, r0, r1, aa;
    bit [31:0] d0, d1;
    bit        al;
    bit [31:0] e_rd0, e_rd1;
    bit [1:0]  e_busy;
    bit [5:0]  e_cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit cen, input bit [1:0] we, input bit [4:0] a0,
                     input bit [31:0] d0, input bit [4:0] a1, input bit [31:0] d1,
                     input bit [4:0] r0, input bit [4:0] r1, input bit al,
                     input bit [4:0] aa, input bit [31:0] e0, input bit [31:0] e1,
                     input bit [1:0] eb, input bit [5:0] ec);
    vec_t v;
    v.cen = cen; v.we = we; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.al = al; v.aa = aa;
    v.e_rd0 = e0; v.e_rd1 = e1; v.e_busy = eb; v.e_cnt = ec;
    tbl.push_back(v);
  endtask

  initial begin
    // Expected values are for the bypassing instance, sampled before the edge.
    add(1, 2'b11, 7, 'h11, 7, 'h22, 7, 0, 0, 0,  'h22, 0,     2'b00, 0); // dual write x7
    add(1, 2'b00, 0, 0,    0, 0,    7, 0, 0, 0,  'h22, 0,     2'b00, 0);
    add(1, 2'b01, 0, 'h1234, 0, 0,  0, 7, 1, 0,  0,    'h22,  2'b00, 0); // x0 ignored
    add(1, 2'b00, 0, 0,    0, 0,    0, 3, 1, 3,  0,    0,     2'b00, 0); // alloc x3
    add(1, 2'b00, 0, 0,    0, 0,    3, 4, 1, 4,  0,    0,     2'b01, 1); // alloc x4
    add(1, 2'b01, 3, 'h55, 0, 0,    3, 4, 0, 0,  'h55, 0,     2'b10, 2); // retire x3
    add(1, 2'b00, 0, 0,    0, 0,    3, 4, 0, 0,  'h55, 0,     2'b10, 1);
    add(1, 2'b00, 0, 0,    0, 0,    9, 4, 1, 9,  0,    0,     2'b10, 1); // alloc x9
    add(1, 2'b10, 0, 0,    9, 'hAA, 9, 4, 1, 9,  'hAA, 0,     2'b11, 2); // write+alloc x9
    add(1, 2'b00, 0, 0,    0, 0,    9, 4, 0, 0,  'hAA, 0,     2'b11, 2);
    add(1, 2'b01, 2, 'h33, 0, 0,    2, 6, 0, 0,  'h33, 0,     2'b00, 2);
    add(0, 2'b01, 2, 'h99, 0, 0,    2, 6, 1, 6,  'h33, 0,     2'b00, 2); // cpu_en=0
    add(1, 2'b00, 0, 0,    0, 0,    2, 6, 0, 0,  'h33, 0,     2'b00, 2);

    model_reset();
    idle_read(0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle_read(5, 31);
    #1 check_model("reset");
    chk("reset cnt", cnt_b, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].cen, tbl[i].we, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1,
            tbl[i].r0, tbl[i].r1, tbl[i].al, tbl[i].aa);
      #1;
      check_model($sformatf("row%0d", i));
      chk($sformatf("row%0d rd0", i),  rd_data_b[31:0],  tbl[i].e_rd0);
      chk($sformatf("row%0d rd1", i),  rd_data_b[63:32], tbl[i].e_rd1);
      chk($sformatf("row%0d busy", i), rd_busy_b,        tbl[i].e_busy);
      chk($sformatf("row%0d cnt", i),  cnt_b,            tbl[i].e_cnt);
      tick();
    end

    // Without bypass the write shows up only after the edge.
    drive(1, 2'b01, 2, 'h99, 0, 0, 2, 0, 0, 0);
    #1;
    chk("nob write-cycle x2", rd_data_n[31:0], 'h33);
    chk("byp write-cycle x2", rd_data_b[31:0], 'h99);
    check_model("nob0");
    tick();
    idle_read(2, 0);
    #1;
    chk("nob next-cycle x2", rd_data_n[31:0], 'h99);
    check_model("nob1");

    // Asynchronous reset between edges, then reset held across a write edge.
    drive(1, 2'b01, 5, 'hDEADBEEF, 0, 0, 5, 0, 1, 10);
    #1 check_model("pre-rst0");
    tick();
    idle_read(5, 10);
    #1 check_model("pre-rst1");
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("async rst x5", rd_data_b[31:0], 0);
    chk("async rst cnt", cnt_b, 0);
    check_model("rst");
    drive(1, 2'b01, 12, 'h77, 0, 0, 12, 13, 1, 13);
    tick();
    rst = 1'b1;
    idle_read(12, 13);
    #1;
    chk("rst-held write x12", rd_data_n[31:0], 0);
    chk("rst-held alloc x13", rd_busy_b[1], 0);
    check_model("post-rst");
    tick();

    for (int n = 0; n < 400; n++) begin
      bit [4:0] a [6];
      for (int q = 0; q < 6; q++)
        a[q] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                           : 5'($urandom_range(0, 7));
      drive($urandom_range(0, 9) != 0, 2'($urandom), a[0], $urandom, a[1], $urandom,
            a[2], a[3], 1'($urandom), a[4]);
      #1 check_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the 5-stage pipeline core; successor to the single-write, two-read register file.
- Adds configurable read-port count, two prioritised write ports and optional same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard with allocate/retire handshake, used by the decode stage for hazard detection.
- Sits between decode (read, allocate) and writeback (write, retire).

Parameters:
- DATA_WIDTH, 32, width of each register.
- REGS_WIDTH, 5, address width; number of registers is 2^REGS_WIDTH.
- NUM_READ, 2, number of read ports (1..4).
- NUM_WRITE, 2, number of write ports (1..2).
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return array contents only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_en  in  1  global enable; when 0, no register write, allocate or retire takes effect.
- wr_en  in  NUM_WRITE  per-port write enable.
- wr_addr  in  NUM_WRITE*REGS_WIDTH  write addresses; port k occupies bits [k*REGS_WIDTH +: REGS_WIDTH].
- wr_data  in  NUM_WRITE*DATA_WIDTH  write data, packed the same way.
- rd_addr  in  NUM_READ*REGS_WIDTH  read addresses, packed.
- rd_data  out  NUM_READ*DATA_WIDTH  read data, packed, combinational.
- rd_busy  out  NUM_READ  scoreboard busy flag for each read address, combinational.
- alloc_en  in  1  marks alloc_addr busy (a new producer has issued).
- alloc_addr  in  REGS_WIDTH  register to allocate.
- busy_count  out  REGS_WIDTH+1  number of currently busy registers, registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers cleared to 0; all busy bits cleared; busy_count=0.
  - rd_data follows the cleared array immediately.
  - Reset asserted mid-write or mid-allocate discards that operation.
- Register x0:
  - Always reads 0; rd_busy is always 0.
  - Writes and allocates to x0 are ignored and never change busy_count.
- Writes:
  - On rising edge, if cpu_en=1 and wr_en[k]=1 and wr_addr[k]!=0, the register takes wr_data[k].
  - Both ports targeting the same address in one cycle: the higher port index wins.
  - Write latency is 1 cycle to the array.
- Reads: rd_data[j] is combinational.
  - BYPASS=1: if any enabled write this cycle (cpu_en=1) matches rd_addr[j]!=0, output that write data (highest matching port index); otherwise output the array value.
  - BYPASS=0: always output the array value; new data is visible the cycle after the edge.
- Scoreboard:
  - Every enabled write (cpu_en=1, addr!=0) retires its register, clearing its busy bit on the edge.
  - alloc_en=1 with cpu_en=1 and alloc_addr!=0 sets that busy bit on the edge.
  - Allocate and write to the same register in one cycle: allocate wins and the busy bit ends at 1 (the newer producer owns it).
  - Allocate to an already-busy register: the bit stays 1 and the count is unchanged.
  - Write to a non-busy register: the data is written and the busy bit stays 0.
- rd_busy[j] = busy[rd_addr[j]]. With BYPASS=1, it is masked to 0 when a same-cycle enabled write retires that register and no same-cycle allocate targets it.
- busy_count:
  - Updated on the same edge as the busy bits.
  - Equals the population count of the busy bits after the edge; never exceeds 2^REGS_WIDTH-1.
  - Implementation may use an incremental +1/-k update but must match the popcount every cycle.
- cpu_en=0: array, busy bits and busy_count hold; reads still operate, and the bypass path is disabled.

Test Plan:
- Reset: write x5=0xDEADBEEF, then pulse rst low between edges -> rd_data for x5 reads 0 immediately; busy_count=0.
- Dual-write conflict: wr_en=2'b11, both ports to x7 with data 0x11 and 0x22 -> after the edge x7=0x22. Same cycle with BYPASS=1, a read of x7 returns 0x22.
- x0 handling: write 0x1234 to x0 and allocate x0 -> reads 0, rd_busy=0, busy_count unchanged.
- Scoreboard: allocate x3 and x4 -> busy_count=2 and rd_busy(x3)=1. Write x3=0x55 -> same cycle rd_busy(x3)=0 (BYPASS=1), then busy_count=1.
- Allocate + retire collision: x9 busy; in one cycle write x9=0xAA and allocate x9 -> x9=0xAA, busy stays 1, busy_count unchanged.
- cpu_en=0: write x2=0x99 and allocate x6 -> x2 keeps its old value and x6 is not busy. Repeat with BYPASS=0 and cpu_en=1 -> read of x2 returns the old value during the write cycle and 0x99 the next cycle.
